// File: rtl/pulse_cdc_pkg.sv
// Shared definitions for the toggle pulse-CDC link: FSM state encoding and a width helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pulse_cdc_pkg;

    // IDLE: nothing in flight. HOLD: a toggle is in flight, waiting for ack echo or gap expiry.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Ceiling log2, used to size the gap counter so it can hold MIN_GAP-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser bringing the asynchronous ack toggle into the source clock domain.
// Latency: NUM_STAGES clk edges from a stable input to q.
// Backpressure: none; free-running level synchroniser.
module sync_chain #(
    parameter int NUM_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    (* syn_preserve = 1 *) logic [NUM_STAGES-1:0] sync_q;

    // Shift the async level through the chain; reset clears every stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], d};
        end
    end

    assign q = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/pulse_toggle_tx.sv
// Source end of the toggle pulse-CDC: turns event pulses into paced level flips on toggle_out.
// Latency: pulse_in with IDLE and empty backlog flips toggle_out on the next clk edge.
// Backpressure: none upstream; bursts queue in a saturating counter, excess events set overflow.
module pulse_toggle_tx
    import pulse_cdc_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter bit USE_ACK    = 1'b1,
    parameter int MIN_GAP    = 4,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    input  logic             ack_toggle,
    input  logic             clr_ovf,
    output logic             toggle_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] pending_nxt;
    logic             toggle_nxt;
    logic             overflow_nxt;
    logic             issue;
    logic             drop;
    logic             release_hold;

    generate
        if (USE_ACK) begin : g_ack
            logic ack_sync;

            sync_chain #(
                .NUM_STAGES(NUM_STAGES)
            ) u_sync_chain (
                .clk  (clk),
                .reset(reset),
                .d    (ack_toggle),
                .q    (ack_sync)
            );

            // The destination has seen the current level once its echo matches what we drive.
            assign release_hold = (ack_sync == toggle_out);
        end else begin : g_gap
            localparam int GAP_W = (clog2(MIN_GAP) < 1) ? 1 : clog2(MIN_GAP);
            localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);

            logic [GAP_W-1:0] gap_cnt;

            // Reload on every issue, then count down to zero to open the next slot.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    gap_cnt <= '0;
                end else if (issue) begin
                    gap_cnt <= GAP_LOAD;
                end else if (gap_cnt != '0) begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
            end

            assign release_hold = (gap_cnt == '0);
        end
    endgenerate

    // Next-state, issue decision, backlog accounting and overflow detection.
    always_comb begin
        state_nxt    = state;
        pending_nxt  = pending;
        toggle_nxt   = toggle_out;
        issue        = 1'b0;
        drop         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pulse_in || (pending != '0)) begin
                    issue = 1'b1;
                end
            end
            ST_HOLD: begin
                if (release_hold) begin
                    // Issue back-to-back from the release cycle so backlog spacing stays tight.
                    if (pulse_in || (pending != '0)) begin
                        issue = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (pulse_in) begin
                    if (pending == PEND_MAX) begin
                        drop = 1'b1;
                    end else begin
                        pending_nxt = pending + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A fresh pulse rides the issue directly; otherwise the toggle consumes one backlog entry.
        if (issue) begin
            toggle_nxt = ~toggle_out;
            state_nxt  = ST_HOLD;
            if (!pulse_in) begin
                pending_nxt = pending - 1'b1;
            end
        end

        // A new drop wins over a same-cycle clear.
        overflow_nxt = drop | (overflow & ~clr_ovf);
    end

    // State, toggle level, backlog and sticky overflow registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            toggle_out <= 1'b0;
            pending    <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            toggle_out <= toggle_nxt;
            pending    <= pending_nxt;
            overflow   <= overflow_nxt;
        end
    end

    assign busy = (state != ST_IDLE) | (pending != '0);

endmodule

// File: tb/tb_pulse_toggle_tx.sv
// Bench for pulse_toggle_tx: one gap-paced and one ack-paced instance against a slot-based model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pulse_toggle_tx;

    localparam int G_GAP  = 4;
    localparam int G_MAXP = 15;
    localparam int A_MAXP = 3;
    localparam int A_SYNC = 2;

    logic       clk;
    logic       rst_gap, rst_ack;
    logic       pulse_gap, pulse_ack;
    logic       clr_gap, clr_ack;
    logic       ack_tgl;
    logic       tog_gap, busy_gap, ovf_gap;
    logic [3:0] pend_gap;
    logic       tog_ack, busy_ack, ovf_ack;
    logic [1:0] pend_ack;

    int checks   = 0;
    int failures = 0;

    // Model state: pend = events waiting, nf = earliest edge a toggle may issue.
    int edge_n   = 0;
    int g_pend   = 0, g_nf = 0, g_acc = 0, g_flips = 0;
    bit g_tog    = 0, g_ovf = 0, g_prev = 0;
    int a_pend   = 0, a_nf = 0, a_acc = 0, a_flips = 0;
    bit a_tog    = 0, a_ovf = 0, a_prev = 0;
    int a_delay  = 3;
    int ack_edge = -1;

    pulse_toggle_tx #(
        .NUM_STAGES(2), .USE_ACK(1'b0), .MIN_GAP(G_GAP), .CNT_W(4)
    ) u_gap (
        .clk(clk), .reset(rst_gap), .pulse_in(pulse_gap), .ack_toggle(1'b0),
        .clr_ovf(clr_gap), .toggle_out(tog_gap), .busy(busy_gap),
        .pending(pend_gap), .overflow(ovf_gap)
    );

    pulse_toggle_tx #(
        .NUM_STAGES(A_SYNC), .USE_ACK(1'b1), .MIN_GAP(4), .CNT_W(2)
    ) u_ack (
        .clk(clk), .reset(rst_ack), .pulse_in(pulse_ack), .ack_toggle(ack_tgl),
        .clr_ovf(clr_ack), .toggle_out(tog_ack), .busy(busy_ack),
        .pending(pend_ack), .overflow(ovf_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // One edge of a link: a slot opens at edge nf; one event leaves per open slot.
    task automatic model_edge(input int e, input bit p, input bit clr, input int maxp,
                              inout int pend, inout int nf, inout bit tog, inout bit ovf,
                              inout int acc, output bit issued);
        bit dropped;
        dropped = 1'b0;
        issued  = 1'b0;
        if (e >= nf && (pend > 0 || p)) begin
            issued = 1'b1;
            tog    = ~tog;
            if (p) acc++;
            else   pend--;
        end else if (p) begin
            if (pend < maxp) begin
                pend++;
                acc++;
            end else begin
                dropped = 1'b1;
            end
        end
        ovf = dropped | (ovf & ~clr);
    endtask

    task automatic compare_all();
        if (tog_gap !== g_prev) g_flips++;
        g_prev = tog_gap;
        if (tog_ack !== a_prev) a_flips++;
        a_prev = tog_ack;
        check("gap_toggle",   tog_gap,  g_tog);
        check("gap_pending",  pend_gap, g_pend);
        check("gap_busy",     busy_gap, (g_pend > 0 || edge_n < g_nf));
        check("gap_overflow", ovf_gap,  g_ovf);
        check("ack_toggle",   tog_ack,  a_tog);
        check("ack_pending",  pend_ack, a_pend);
        check("ack_busy",     busy_ack, (a_pend > 0 || edge_n < a_nf));
        check("ack_overflow", ovf_ack,  a_ovf);
    endtask

    // Called at a negedge: drive inputs, take one posedge, update models, drive ack echo, compare.
    task automatic step(input bit pg, input bit pa, input bit cg, input bit ca);
        bit iss;
        pulse_gap = pg;
        pulse_ack = pa;
        clr_gap   = cg;
        clr_ack   = ca;
        @(posedge clk);
        edge_n++;
        model_edge(edge_n, pg, cg, G_MAXP, g_pend, g_nf, g_tog, g_ovf, g_acc, iss);
        if (iss) g_nf = edge_n + G_GAP;
        model_edge(edge_n, pa, ca, A_MAXP, a_pend, a_nf, a_tog, a_ovf, a_acc, iss);
        if (iss) begin
            ack_edge = edge_n + a_delay;
            a_nf     = ack_edge + A_SYNC + 1;
        end
        if (edge_n == ack_edge) begin
            #1;
            ack_tgl = a_tog;
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_gap = 1'b0; rst_ack = 1'b0;
        pulse_gap = 1'b0; pulse_ack = 1'b0;
        clr_gap = 1'b0; clr_ack = 1'b0;
        ack_tgl = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_gap_toggle", tog_gap, 0);
        check("rst_gap_busy",   busy_gap, 0);
        check("rst_gap_pend",   pend_gap, 0);
        check("rst_ack_ovf",    ovf_ack, 0);
        rst_gap = 1'b1; rst_ack = 1'b1;
        idle(3);

        // Single event on each link, then a three-pulse burst.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("single_flip", tog_gap, 1);
        idle(8);
        a_delay = 9;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("burst_pend", pend_gap, 2);
        idle(30);

        // Ack held off: saturate the ack link and drop with a concurrent clear.
        a_delay = 40;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("sat_pend", pend_ack, 3);
        check("sat_ovf",  ovf_ack, 1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("clr_vs_drop", ovf_ack, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_alone", ovf_ack, 0);
        a_delay = 3;
        idle(70);

        // Reset the gap link mid-HOLD with a backlog of two.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_reset_pend", pend_gap, 2);
        rst_gap = 1'b0;
        #1;
        check("mid_rst_toggle", tog_gap, 0);
        check("mid_rst_busy",   busy_gap, 0);
        check("mid_rst_pend",   pend_gap, 0);
        g_pend = 0; g_nf = 0; g_tog = 0; g_ovf = 0; g_prev = 0; g_acc = 0; g_flips = 0;
        @(negedge clk);
        rst_gap = 1'b1;
        idle(10);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(6);

        // Random traffic on both links with random echo delay.
        for (int i = 0; i < 2000; i++) begin
            a_delay = $urandom_range(1, 5);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0));
        end
        idle(120);
        check("gap_flips_vs_accepted", g_flips, g_acc);
        check("ack_flips_vs_accepted", a_flips, a_acc);
        check("gap_drained", pend_gap, 0);
        check("ack_drained", pend_ack, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
